// File: rtl/dds_freq_meter.sv
// dds_freq_meter: frequency word of a sampled periodic waveform, from the span of 2^AVG_LOG2 rising mid-scale crossings.
// Latency: valid pulses FW_W+2 clk edges after the edge that samples the final crossing (1 detect stage + FW_W divide steps + 1 result load).
// Backpressure: none; start is honoured only in IDLE and not in the clk where valid is high. Optional macro: DDS_FREQ_METER_HYST_EN.
module dds_freq_meter #(
    parameter int DAT_W    = 14,
    parameter int FW_W     = 32,
    parameter int AVG_LOG2 = 3,
    parameter int TMO_W    = 24,
    parameter int HYST     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_dff_en,
    input  logic [DAT_W-1:0] din,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [TMO_W-1:0] ticks,
    output logic [FW_W-1:0]  freq_word_out
);

`ifdef DDS_FREQ_METER_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    // Zero band: a crossing is simply "previous enabled sample below mid, current at/above mid".
    localparam int HYST_EFF = 0;
`endif

    localparam int MID     = 1 << (DAT_W - 1);
    localparam int HI_THR  = MID + HYST_EFF;
    localparam int LO_THR  = MID - HYST_EFF;
    localparam int PERIODS = 1 << AVG_LOG2;
    localparam int PER_W   = AVG_LOG2 + 1;
    localparam int REM_W   = TMO_W + 1;
    localparam int BIT_W   = $clog2(FW_W);

    localparam logic [TMO_W-1:0] TICK_MAX = '1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW_W - 1);
    // Quotient bits above FW_W-1 are zero whenever ticks > 2^AVG_LOG2, so the
    // partial remainder entering the first kept bit is just 2^AVG_LOG2.
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(PERIODS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_MEAS = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;

    logic             start_acc;
    int               din_int;
    logic             smp_lo, smp_hi, cross_now;
    logic             low_q, en_q, cross_q;

    logic [TMO_W-1:0] tick_q;
    logic [PER_W-1:0] per_q;
    logic             tmo_q;
    logic             tick_max, fin_cross, div_last;

    logic [TMO_W-1:0] den_q;
    logic [REM_W-1:0] rem_q, rem_shl;
    logic [FW_W-1:0]  quo_q;
    logic [BIT_W-1:0] bit_q;
    logic             q_bit, div_sat;

    logic             valid_q, timeout_q;
    logic [TMO_W-1:0] ticks_q;
    logic [FW_W-1:0]  freq_q;

    // A start coinciding with valid is dropped even though the FSM is already back in IDLE.
    assign start_acc = start && (state_q == S_IDLE) && !valid_q;

    assign din_int   = int'(din);
    assign smp_lo    = (din_int < LO_THR);
    assign smp_hi    = (din_int >= HI_THR);
    assign cross_now = low_q && smp_hi;

    assign tick_max  = (tick_q == TICK_MAX);
    assign fin_cross = cross_q && (per_q == PER_LAST);
    assign div_last  = (bit_q == BIT_LAST);

    assign rem_shl   = {rem_q[REM_W-2:0], 1'b0};
    assign q_bit     = (rem_shl >= {1'b0, den_q});
    assign div_sat   = ({1'b0, den_q} <= REM_INIT);

    // Crossing detector: evaluated on enabled samples only, registered so the FSM sees a clean one-cycle stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_q   <= 1'b0;
            en_q    <= 1'b0;
            cross_q <= 1'b0;
        end else if (start_acc) begin
            low_q   <= 1'b0;
            en_q    <= 1'b0;
            cross_q <= 1'b0;
        end else begin
            en_q    <= int_dff_en;
            cross_q <= int_dff_en && cross_now;
            if (int_dff_en) begin
                if (cross_now) begin
                    low_q <= 1'b0;
                end else if (smp_lo) begin
                    low_q <= 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: timeout on a saturated tick counter wins over a same-sample crossing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc) state_d = S_ARM;
            end
            S_ARM: begin
                if (en_q) begin
                    if (tick_max)     state_d = S_DONE;
                    else if (cross_q) state_d = S_MEAS;
                end
            end
            S_MEAS: begin
                if (en_q) begin
                    if (tick_max)       state_d = S_DONE;
                    else if (fin_cross) state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (div_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Tick/period counting, restoring divider and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q    <= '0;
            per_q     <= '0;
            tmo_q     <= 1'b0;
            den_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bit_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ticks_q   <= '0;
            freq_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        tick_q <= '0;
                        per_q  <= '0;
                        tmo_q  <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (en_q) begin
                        if (tick_max) begin
                            tmo_q <= 1'b1;
                        end else if (cross_q) begin
                            tick_q <= '0;
                        end else begin
                            tick_q <= tick_q + TMO_W'(1);
                        end
                    end
                end
                S_MEAS: begin
                    if (en_q) begin
                        if (tick_max) begin
                            tmo_q <= 1'b1;
                        end else begin
                            tick_q <= tick_q + TMO_W'(1);
                            if (cross_q) begin
                                per_q <= per_q + PER_W'(1);
                                if (per_q == PER_LAST) begin
                                    den_q <= tick_q + TMO_W'(1);
                                    rem_q <= REM_INIT;
                                    quo_q <= '0;
                                    bit_q <= '0;
                                end
                            end
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= q_bit ? (rem_shl - {1'b0, den_q}) : rem_shl;
                    quo_q <= {quo_q[FW_W-2:0], q_bit};
                    bit_q <= bit_q + BIT_W'(1);
                end
                S_DONE: begin
                    valid_q   <= 1'b1;
                    timeout_q <= tmo_q;
                    ticks_q   <= tmo_q ? TICK_MAX : den_q;
                    freq_q    <= tmo_q ? '0 : (div_sat ? '1 : quo_q);
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid         = valid_q;
    assign timeout       = timeout_q;
    assign ticks         = ticks_q;
    assign freq_word_out = freq_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter: DDS sine, constant and square stimulus with hand-computed results.
module tb_dds_freq_meter;
    localparam int DAT_W    = 14;
    localparam int FW_W     = 32;
    localparam int AVG_LOG2 = 3;
    localparam int TMO_W    = 12;
    localparam int HYST     = 64;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             int_dff_en = 1'b0;
    logic             start      = 1'b0;
    logic [DAT_W-1:0] din        = '0;
    logic             busy, valid, timeout;
    logic [TMO_W-1:0] ticks;
    logic [FW_W-1:0]  freq_word_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          mode    = 0;
    int          en_div  = 1;
    int          smp_idx = 0;
    int          noise   = 0;
    int          x_cyc   = 0;
    logic [31:0] fw_b    = 32'h0400_0000;
    logic        dup_busy = 1'b0;

    logic             got;
    int               vcyc, nv, nb;
    logic [TMO_W-1:0] tk;
    logic [FW_W-1:0]  fq;
    logic             to;

    dds_freq_meter #(
        .DAT_W(DAT_W), .FW_W(FW_W), .AVG_LOG2(AVG_LOG2), .TMO_W(TMO_W), .HYST(HYST)
    ) dut (
        .clk(clk), .rst(rst), .int_dff_en(int_dff_en), .din(din), .start(start),
        .busy(busy), .valid(valid), .timeout(timeout), .ticks(ticks), .freq_word_out(freq_word_out)
    );

`ifdef DDS_FREQ_METER_HYST_EN
    logic             busy_h, valid_h, timeout_h;
    logic [TMO_W-1:0] ticks_h;
    logic [FW_W-1:0]  freq_h;

    dds_freq_meter #(
        .DAT_W(DAT_W), .FW_W(FW_W), .AVG_LOG2(AVG_LOG2), .TMO_W(TMO_W), .HYST(9000)
    ) dut_h (
        .clk(clk), .rst(rst), .int_dff_en(int_dff_en), .din(din), .start(start),
        .busy(busy_h), .valid(valid_h), .timeout(timeout_h), .ticks(ticks_h), .freq_word_out(freq_h)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DAT_W-1:0] gen(input int idx);
        logic [31:0] acc;
        real         ph;
        int          v;
        gen = '0;
        case (mode)
            0: begin
                acc = 32'(idx) * fw_b;
                ph  = 6.283185307179586 * real'(acc) / 4294967296.0;
                v   = 8192 + $rtoi($floor(8000.0 * $sin(ph) + 0.5));
                if (noise != 0) v = v + int'($urandom_range(200)) - 100;
                gen = DAT_W'(v);
            end
            1: gen = 14'h2000;
            default: gen = (idx % 2 == 1) ? 14'h3FFF : 14'h0000;
        endcase
    endfunction

    // Called at a negedge; disabled cycles carry junk on din.
    task automatic drive_sample();
        if ((cyc % en_div) == 0) begin
            int_dff_en = 1'b1;
            din        = gen(smp_idx);
            if (mode == 2 && smp_idx == 17) x_cyc = cyc;
            smp_idx++;
        end else begin
            int_dff_en = 1'b0;
            din        = DAT_W'($urandom);
        end
    endtask

    task automatic measure(input int budget, input int dup_at, output logic g, output int vc,
                           output logic [TMO_W-1:0] t, output logic [FW_W-1:0] f, output logic o);
        g = 1'b0; vc = 0; t = '0; f = '0; o = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        int_dff_en = 1'b0;
        smp_idx    = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (valid === 1'b1) begin
                g = 1'b1; vc = cyc; t = ticks; f = freq_word_out; o = timeout;
                int_dff_en = 1'b0;
                break;
            end
            if (i == dup_at) begin
                start    = 1'b1;
                dup_busy = busy;
            end
            drive_sample();
        end
    endtask

    task automatic watch(input int n, input logic start_first, output int nvo, output int nbo);
        nvo = 0; nbo = 0;
        for (int i = 0; i < n; i++) begin
            start = (i == 0) && start_first;
            drive_sample();
            @(negedge clk);
            if (valid === 1'b1) nvo++;
            if (busy === 1'b1) nbo++;
        end
        start = 1'b0;
        int_dff_en = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ticks", ticks, 0);
        chk("rst_freq", freq_word_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef DDS_FREQ_METER_HYST_EN
        // Square wave: normal DUT measures, the wide-band DUT never crosses and times out
        mode = 2; en_div = 1; noise = 0;
        measure(200, -1, got, vcyc, tk, fq, to);
        chk("hsq_got", got, 1);
        chk("hsq_ticks", tk, 16);
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (valid_h === 1'b1) begin
                got = 1'b1; to = timeout_h; tk = ticks_h; fq = freq_h;
            end else begin
                drive_sample();
            end
        end
        int_dff_en = 1'b0;
        chk("hwide_got", got, 1);
        chk("hwide_timeout", to, 1);
        chk("hwide_ticks", tk, 12'hFFF);
        chk("hwide_freq", fq, 0);
        repeat (2) @(negedge clk);
`endif

        // DDS sine fw=0x04000000 (64 samples/period), strobe every 3rd clk, extra start while busy
        mode = 0; en_div = 3; noise = 0;
        measure(3000, 300, got, vcyc, tk, fq, to);
        chk("sine_got", got, 1);
        chk("sine_ticks", tk, 512);
        chk("sine_freq", fq, 32'h0400_0000);
        chk("sine_timeout", to, 0);
        chk("sine_dup_start_busy", dup_busy, 1);
        watch(100, 1'b1, nv, nb);
        chk("sine_extra_valid", nv, 0);
        chk("sine_busy_after_start_on_valid", nb, 0);

        // Square wave, strobe every clk: 2 samples/period
        mode = 2; en_div = 1;
        measure(200, -1, got, vcyc, tk, fq, to);
        chk("sq_got", got, 1);
        chk("sq_ticks", tk, 16);
        chk("sq_freq", fq, 32'h8000_0000);
        chk("sq_timeout", to, 0);
        chk("sq_latency", vcyc - x_cyc, FW_W + 3);

        // Constant mid-scale: no crossing -> timeout
        mode = 1; en_div = 1;
        measure(5000, -1, got, vcyc, tk, fq, to);
        chk("const_got", got, 1);
        chk("const_timeout", to, 1);
        chk("const_ticks", tk, 12'hFFF);
        chk("const_freq", fq, 0);

        // Reset while dividing, then sine without start, then a fresh measurement
        mode = 2; en_div = 1;
        measure(28, -1, got, vcyc, tk, fq, to);
        chk("rdiv_no_valid_yet", got, 0);
        chk("rdiv_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("rdiv_busy", busy, 0);
        chk("rdiv_timeout", timeout, 0);
        chk("rdiv_ticks", ticks, 0);
        chk("rdiv_freq", freq_word_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mode = 0; en_div = 1;
        watch(300, 1'b0, nv, nb);
        chk("rdiv_idle_valid", nv, 0);
        chk("rdiv_idle_busy", nb, 0);
        measure(1500, -1, got, vcyc, tk, fq, to);
        chk("rdiv2_got", got, 1);
        chk("rdiv2_ticks", tk, 512);
        chk("rdiv2_freq", fq, 32'h0400_0000);
        chk("rdiv2_timeout", to, 0);

`ifdef DDS_FREQ_METER_HYST_EN
        // Sine plus +/-100 LSB noise: result within 1% of 0x04000000
        mode = 0; en_div = 1; noise = 1;
        measure(1500, -1, got, vcyc, tk, fq, to);
        chk("noise_got", got, 1);
        chk("noise_timeout", to, 0);
        chk("noise_freq_1pct", (fq >= 32'd66437776) && (fq <= 32'd67779952), 1);
        noise = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
